hazard_pipe: RTL and testbench
==============================

HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 The module SHALL have parameter STALL_CNT_W, default 16, giving the width of the load-use stall counter.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have ports Rs1D and Rs2D, input, 5 bits each: source registers of the instruction in Decode.
REQ-005 The module SHALL have port RdD, input, 5 bits: destination register in Decode.
REQ-006 The module SHALL have port RegWriteD, input, 1 bit: Decode instruction writes the register file.
REQ-007 The module SHALL have port MemReadD, input, 1 bit: Decode instruction is a load.
REQ-008 The module SHALL have port PCSrcE, input, 1 bit: taken branch or jump resolved in Execute.
REQ-009 The module SHALL have ports Rs1E, Rs2E, RdE, RdM and RdW, output, 5 bits each: pipelined register addresses, consumed by the forwarding unit.
REQ-010 The module SHALL have ports RegWriteE, RegWriteM and RegWriteW, output, 1 bit each: pipelined write enables.
REQ-011 The module SHALL have port MemReadE, output, 1 bit: the Execute instruction is a load.
REQ-012 The module SHALL have ports StallF, StallD, FlushD and FlushE, output, 1 bit each: pipeline control to the fetch and decode registers.
REQ-013 The module SHALL have port stall_cnt, output, STALL_CNT_W bits: number of load-use stall cycles.

Function
REQ-014 lwStall SHALL be MemReadE & (RdE != 0) & ((Rs1D == RdE) | (Rs2D == RdE)), computed combinationally from current state and inputs.
REQ-015 StallF and StallD SHALL both equal lwStall & ~PCSrcE; the branch takes priority over the stall.
REQ-016 FlushD SHALL equal PCSrcE.
REQ-017 FlushE SHALL equal lwStall | PCSrcE.
REQ-018 D->E register: on a clock edge with FlushE=1, Rs1E, Rs2E, RdE, RegWriteE and MemReadE SHALL all load 0 (a bubble); otherwise they SHALL load Rs1D, Rs2D, RdD, RegWriteD and MemReadD.
REQ-019 E->M register: RdM and RegWriteM SHALL load RdE and RegWriteE every cycle; this stage never stalls.
REQ-020 M->W register: RdW and RegWriteW SHALL load RdM and RegWriteM every cycle.
REQ-021 A load followed by a dependent instruction SHALL produce exactly one stall cycle; latency from the load entering E to StallD rising is 0 cycles (combinational).
REQ-022 stall_cnt SHALL increment by 1 on each edge where StallD=1 and SHALL saturate at all-ones without wrapping.
REQ-023 A register address of x0 SHALL never cause a stall, regardless of the values of MemReadE and Rs1D/Rs2D.
REQ-024 When lwStall and PCSrcE are both 1 in the same cycle, the module SHALL output StallF=StallD=0, FlushD=1 and FlushE=1, and stall_cnt SHALL NOT increment.
REQ-025 A bubble inserted into E SHALL propagate to M and then W, with RegWrite=0 and Rd=0 at each stage.

Reset
REQ-026 On an edge with rst=1, all E, M and W registers and stall_cnt SHALL clear to 0; rst SHALL override FlushE and normal loading.
REQ-027 During rst=1, the outputs StallF, StallD, FlushD and FlushE SHALL be derived from the cleared state (StallF/StallD=0 while MemReadE=0); rst asserted mid-stall SHALL abort the stall on the next edge.
REQ-028 Outputs SHALL be valid 0 from the first edge after rst is asserted, with no X values.

Verification
REQ-029 Load-use: load x5 (RdD=5, MemReadD=1), then Rs1D=5 -> next cycle StallF=StallD=FlushE=1 for exactly one cycle, the bubble reaches M then W, and stall_cnt=1.
REQ-030 No hazard: load x5, then Rs1D=6 and Rs2D=7 -> no stall; Rd values shift E->M->W on consecutive cycles; stall_cnt=0.
REQ-031 x0 destination: load with RdD=0, then Rs1D=0 -> StallD=0.
REQ-032 Simultaneous events: force MemReadE=1, RdE=3, Rs2D=3 and PCSrcE=1 -> StallD=0, FlushD=1, FlushE=1, and stall_cnt is unchanged.
REQ-033 Saturation: with STALL_CNT_W=4, drive 20 load-use pairs -> stall_cnt holds at 15.
REQ-034 Mid-stall reset: assert rst during the stall cycle -> next edge gives all pipelined outputs 0, StallD=0 and stall_cnt=0.

Source files
------------

// File: rtl/hazard_pipe.sv
// hazard_pipe: load-use stall/flush control with pipelined register addresses for forwarding.
module hazard_pipe #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             Rs1D,
  input  logic [4:0]             Rs2D,
  input  logic [4:0]             RdD,
  input  logic                   RegWriteD,
  input  logic                   MemReadD,
  input  logic                   PCSrcE,
  output logic [4:0]             Rs1E,
  output logic [4:0]             Rs2E,
  output logic [4:0]             RdE,
  output logic [4:0]             RdM,
  output logic [4:0]             RdW,
  output logic                   RegWriteE,
  output logic                   RegWriteM,
  output logic                   RegWriteW,
  output logic                   MemReadE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic lwStall;
  always_comb begin
    lwStall = MemReadE & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));
    StallF  = lwStall & ~PCSrcE;
    StallD  = lwStall & ~PCSrcE;
    FlushD  = PCSrcE;
    FlushE  = lwStall | PCSrcE;
  end
  // A flushed D->E load becomes a bubble that then drains through M and W.
  always_ff @(posedge clk) begin
    if (rst) begin
      Rs1E      <= '0;
      Rs2E      <= '0;
      RdE       <= '0;
      RegWriteE <= 1'b0;
      MemReadE  <= 1'b0;
      RdM       <= '0;
      RegWriteM <= 1'b0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      stall_cnt <= '0;
    end else begin
      Rs1E      <= FlushE ? 5'd0 : Rs1D;
      Rs2E      <= FlushE ? 5'd0 : Rs2D;
      RdE       <= FlushE ? 5'd0 : RdD;
      RegWriteE <= FlushE ? 1'b0 : RegWriteD;
      MemReadE  <= FlushE ? 1'b0 : MemReadD;
      RdM       <= RdE;
      RegWriteM <= RegWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
      if (StallD && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe: directed checks of stall/flush control, bubble propagation, saturation and reset.
module tb_hazard_pipe;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic RegWriteD, MemReadD, PCSrcE;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW, MemReadE;
  logic StallF, StallD, FlushD, FlushE;
  logic [3:0] stall_cnt;
  int checks = 0;
  int failures = 0;
  logic [3:0] expCnt;

  always #5 clk = ~clk;

  hazard_pipe #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .PCSrcE(PCSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setD(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic pc);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; MemReadD = mr; PCSrcE = pc;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    setD(0, 0, 0, 0, 0, 0);
    step;
    step;
    rst = 1'b0;
    chk("rst_RdE", RdE, 0);
    chk("rst_RdM", RdM, 0);
    chk("rst_RdW", RdW, 0);
    chk("rst_RegWrite", {RegWriteE, RegWriteM, RegWriteW, MemReadE}, 0);
    chk("rst_ctrl", {StallF, StallD, FlushD, FlushE}, 0);
    chk("rst_cnt", stall_cnt, 0);
    // load x5 then dependent use of x5
    setD(0, 0, 5, 1, 1, 0);
    step;
    chk("lu_RdE", RdE, 5);
    setD(5, 0, 6, 1, 0, 0);
    chk("lu_ctrl", {StallF, StallD, FlushD, FlushE}, 4'b1101);
    step;
    chk("lu_bubbleE", {RdE, RegWriteE, MemReadE}, 0);
    chk("lu_M", {RdM, RegWriteM}, {5'd5, 1'b1});
    chk("lu_unstall", {StallF, StallD, FlushE}, 0);
    chk("lu_cnt", stall_cnt, 1);
    step;
    chk("lu_E2", {RdE, RegWriteE}, {5'd6, 1'b1});
    chk("lu_bubbleM", {RdM, RegWriteM}, 0);
    chk("lu_W", {RdW, RegWriteW}, {5'd5, 1'b1});
    setD(0, 0, 0, 0, 0, 0);
    step;
    chk("lu_bubbleW", {RdW, RegWriteW}, 0);
    chk("lu_M2", RdM, 6);
    chk("lu_cnt2", stall_cnt, 1);
    // load x5 then independent instruction
    setD(0, 0, 5, 1, 1, 0);
    step;
    setD(6, 7, 8, 1, 0, 0);
    chk("nh_ctrl", {StallF, StallD, FlushD, FlushE}, 0);
    step;
    chk("nh_E", {Rs1E, Rs2E, RdE}, {5'd6, 5'd7, 5'd8});
    chk("nh_M", RdM, 5);
    setD(0, 0, 0, 0, 0, 0);
    step;
    chk("nh_MW", {RdM, RdW}, {5'd8, 5'd5});
    step;
    chk("nh_W", RdW, 8);
    chk("nh_cnt", stall_cnt, 1);
    // load to x0 never stalls
    setD(0, 0, 0, 1, 1, 0);
    step;
    chk("x0_MemReadE", MemReadE, 1);
    setD(0, 0, 1, 1, 0, 0);
    chk("x0_ctrl", {StallF, StallD, FlushE}, 0);
    // load-use coinciding with a taken branch
    setD(0, 0, 3, 1, 1, 0);
    step;
    setD(0, 3, 4, 1, 0, 1);
    chk("br_ctrl", {StallF, StallD, FlushD, FlushE}, 4'b0011);
    step;
    chk("br_flushE", {RdE, RegWriteE, MemReadE}, 0);
    chk("br_cnt", stall_cnt, 1);
    // reset during a stall cycle
    setD(0, 0, 5, 1, 1, 0);
    step;
    setD(0, 5, 0, 0, 0, 0);
    chk("mr_stall", StallD, 1);
    rst = 1'b1;
    step;
    chk("mr_regs", {RdE, RdM, RdW, Rs1E, Rs2E}, 0);
    chk("mr_flags", {RegWriteE, RegWriteM, RegWriteW, MemReadE, StallD, StallF}, 0);
    chk("mr_cnt", stall_cnt, 0);
    rst = 1'b0;
    // saturation of the 4-bit counter over 20 load-use pairs
    expCnt = 4'd0;
    for (int i = 0; i < 20; i++) begin
      setD(0, 0, 9, 1, 1, 0);
      step;
      setD(9, 0, 2, 1, 0, 0);
      step;
      expCnt = (expCnt == 4'hf) ? 4'hf : expCnt + 4'd1;
      chk($sformatf("sat_%0d", i), stall_cnt, expCnt);
    end
    chk("sat_final", stall_cnt, 4'hf);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
